led_step_fader: RTL

Multi-channel step-level PWM dimmer with soft fading. It is the parametrised successor of the single-channel 4-step LED controller.
- Each channel holds a brightness level stepped up or down by single-cycle button pulses, or cleared globally.
- The level maps to a target duty. The applied duty ramps toward that target one unit at a time, so brightness changes fade instead of jumping.
- The PWM generator is built in, and duty changes take effect only at period boundaries, so no output pulse is ever truncated.
- It sits between the debounced button edge detectors and the LED/fan drive pins.

---
 rtl/led_step_fader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/led_step_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_step_fader
// Brief    : Multi-channel step-level PWM dimmer. The applied duty fades one
//            unit at a time and only updates the PWM output at period ends.
// Revision : 1.0 - initial release
// ============================================================================
module led_step_fader #(
    parameter int CH       = 3,
    parameter int STEPS    = 4,
    parameter int DUTY_MAX = 100,
    parameter int DUTY_W   = 7,
    parameter int PWM_DIV  = 125,
    parameter int RAMP_DIV = 1,
    parameter int FADE     = 1,
    parameter int WRAP     = 1,
    localparam int LVL_W   = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [CH-1:0]         step_up,
    input  logic [CH-1:0]         step_dn,
    input  logic                  clr,
    output logic [CH-1:0]         pwm,
    output logic [CH*LVL_W-1:0]   level,
    output logic [CH-1:0]         busy
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int RMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PRE_W-1:0]  c_pre_last = PRE_W'(PWM_DIV - 1);
    localparam logic [DUTY_W-1:0] c_cnt_last = DUTY_W'(DUTY_MAX - 1);
    localparam logic [RMP_W-1:0]  c_rmp_last = RMP_W'(RAMP_DIV - 1);
    localparam logic [LVL_W-1:0]  c_lvl_top  = LVL_W'(STEPS - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [RMP_W-1:0]  r_fade_cnt;
    logic              w_tick;
    logic              w_period_end;
    logic              w_ramp_step;

    assign w_tick       = (r_pre == c_pre_last);
    assign w_period_end = w_tick && (r_pwm_cnt == c_cnt_last);
    assign w_ramp_step  = w_period_end && (r_fade_cnt == c_rmp_last);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Counter shared by every channel so all PWM periods stay aligned
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            if (r_pwm_cnt == c_cnt_last) begin
                r_pwm_cnt <= '0;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_fade_cnt <= '0;
        end else if (w_period_end) begin
            if (r_fade_cnt == c_rmp_last) begin
                r_fade_cnt <= '0;
            end else begin
                r_fade_cnt <= r_fade_cnt + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [LVL_W-1:0]  r_level;
        logic [DUTY_W-1:0] w_tgt;
        logic [DUTY_W-1:0] r_cur;
        logic [DUTY_W-1:0] r_duty_lat;

        // Top level maps exactly onto DUTY_MAX; lower levels floor
        assign w_tgt = DUTY_W'((32'(r_level) * 32'(DUTY_MAX)) / 32'(STEPS - 1));

        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                r_level <= '0;
            end else if (clr) begin
                r_level <= '0;
            end else if (step_up[gi] && step_dn[gi]) begin
                r_level <= r_level;
            end else if (step_up[gi]) begin
                if (r_level == c_lvl_top) begin
                    r_level <= (WRAP != 0) ? '0 : r_level;
                end else begin
                    r_level <= r_level + 1'b1;
                end
            end else if (step_dn[gi] && (r_level != '0)) begin
                r_level <= r_level - 1'b1;
            end
        end

        // Retargeting mid-fade continues from the present value
        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                r_cur <= '0;
            end else if (FADE == 0) begin
                r_cur <= w_tgt;
            end else if (w_ramp_step) begin
                if (r_cur < w_tgt) begin
                    r_cur <= r_cur + 1'b1;
                end else if (r_cur > w_tgt) begin
                    r_cur <= r_cur - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                r_duty_lat <= '0;
            end else if (w_period_end) begin
                r_duty_lat <= r_cur;
            end
        end

        assign pwm[gi]                    = (r_pwm_cnt < r_duty_lat);
        assign busy[gi]                   = (r_cur != w_tgt);
        assign level[gi*LVL_W +: LVL_W]   = r_level;
    end

endmodule
`default_nettype wire
